// File: rtl/core_sequencer_if.sv
// core_sequencer_if
// Groups the instruction-fetch and data-memory handshake signals of the
// sequencer.
//   master : sequencer side (drives requests, receives valid/done/data)
//   slave  : memory side    (receives requests, drives valid/done/data)
// Handshake: a request is held high for the whole FETCH (imem_req) or MEM
// (dmem_req) state. The memory answers by raising imem_valid / dmem_done
// for one cycle. The response is sampled on the rising edge only while the
// matching request is high, and is ignored at all other times.
interface core_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_done;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata,
        output dmem_req,
        input  dmem_done
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata,
        input  dmem_req,
        output dmem_done
    );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle control FSM for the RV32 core:
// FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK.
// It holds the instruction register and the retired-instruction counter,
// and produces one pc_enable strobe per retired instruction.
// Ports:
//   clk, reset (async, active-low)
//   run                            level, core may execute while high
//   pc_in                          current PC
//   mem (core_sequencer_if.master) imem/dmem handshakes
//   instr_out, instr_valid         instruction register and its qualifier
//   is_mem, no_wb, illegal, is_branch, branch_taken   decoder/execute info
//   regfile_we, pc_enable, pc_jump                    writeback strobes
//   halt_req, halted               halt at an instruction boundary
//   fault                          sticky memory-timeout / illegal fault
//   state                          encoded FSM state for debug
//   instret                        retired-instruction count (wraps)
module core_sequencer #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] RESET_INSTR    = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [31:0]              pc_in,
    core_sequencer_if.master         mem,
    output logic [31:0]              instr_out,
    output logic                     instr_valid,
    input  logic                     is_mem,
    input  logic                     no_wb,
    input  logic                     illegal,
    input  logic                     is_branch,
    input  logic                     branch_taken,
    output logic                     regfile_we,
    output logic                     pc_enable,
    output logic                     pc_jump,
    input  logic                     halt_req,
    output logic                     halted,
    output logic                     fault,
    output logic [2:0]               state,
    output logic [31:0]              instret
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6,
        FAULT     = 3'd7
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      st_q, st_d;
    logic [7:0]  wait_cnt;
    logic        imem_req_c;
    logic        dmem_req_c;
    logic        waiting;
    logic        timed_out;

    // A wait cycle is one spent in FETCH/MEM without a response. The
    // counter is zero everywhere else, so it is cleared on entry to
    // either waiting state.
    assign waiting   = (st_q == FETCH && !mem.imem_valid) ||
                       (st_q == MEM   && !mem.dmem_done);
    assign timed_out = waiting && (wait_cnt == TO_LAST);

    assign state         = st_q;
    assign mem.imem_req  = imem_req_c;
    assign mem.imem_addr = imem_req_c ? pc_in : 32'd0;
    assign mem.dmem_req  = dmem_req_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q      <= IDLE;
            wait_cnt  <= 8'd0;
            instr_out <= RESET_INSTR;
            instret   <= 32'd0;
        end else begin
            st_q     <= st_d;
            wait_cnt <= waiting ? wait_cnt + 8'd1 : 8'd0;
            if (st_q == FETCH && mem.imem_valid) begin
                instr_out <= mem.imem_rdata;
            end
            if (st_q == WRITEBACK) begin
                instret <= instret + 32'd1;
            end
        end
    end

    always_comb begin
        st_d        = st_q;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        instr_valid = 1'b0;
        regfile_we  = 1'b0;
        pc_enable   = 1'b0;
        pc_jump     = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (st_q)
            IDLE: begin
                if (run) st_d = FETCH;
            end
            FETCH: begin
                imem_req_c = 1'b1;
                // A response in the final allowed cycle still wins.
                if (mem.imem_valid) st_d = DECODE;
                else if (timed_out) st_d = FAULT;
            end
            DECODE: begin
                instr_valid = 1'b1;
                st_d        = illegal ? FAULT : EXECUTE;
            end
            EXECUTE: begin
                instr_valid = 1'b1;
                st_d        = is_mem ? MEM : WRITEBACK;
            end
            MEM: begin
                instr_valid = 1'b1;
                dmem_req_c  = 1'b1;
                if (mem.dmem_done) st_d = WRITEBACK;
                else if (timed_out) st_d = FAULT;
            end
            WRITEBACK: begin
                instr_valid = 1'b1;
                regfile_we  = !no_wb;
                pc_enable   = 1'b1;
                pc_jump     = is_branch & branch_taken;
                // halt_req outranks run=0 at the instruction boundary.
                if (halt_req)  st_d = HALT;
                else if (!run) st_d = IDLE;
                else           st_d = FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (!halt_req) st_d = run ? FETCH : IDLE;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: st_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer
// Directed bench for core_sequencer (TIMEOUT_CYCLES = 8). Stimulus pushes
// the expected retirement record {regfile_we, pc_jump, instret, latency}
// into exp_q. A negedge monitor pops and compares one record on every
// pc_enable strobe; a strobe with nothing expected is an error.
module tb_core_sequencer;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        run;
    logic [31:0] pc_in;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        is_mem, no_wb, illegal, is_branch, branch_taken;
    logic        regfile_we, pc_enable, pc_jump;
    logic        halt_req, halted, fault;
    logic [2:0]  state;
    logic [31:0] instret;

    core_sequencer_if mem_if ();

    core_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .RESET_INSTR   (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .pc_in       (pc_in),
        .mem         (mem_if),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .is_mem      (is_mem),
        .no_wb       (no_wb),
        .illegal     (illegal),
        .is_branch   (is_branch),
        .branch_taken(branch_taken),
        .regfile_we  (regfile_we),
        .pc_enable   (pc_enable),
        .pc_jump     (pc_jump),
        .halt_req    (halt_req),
        .halted      (halted),
        .fault       (fault),
        .state       (state),
        .instret     (instret)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fetch_start = 0;
    logic [2:0]  prev_state = 3'd0;
    logic [41:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_retire(input logic we, input logic jump, input logic [31:0] ir, input logic [7:0] lat);
        exp_q.push_back({we, jump, ir, lat});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string name);
        int n;
        n = 0;
        while (state !== s && n < max) begin
            step();
            n++;
        end
        check(name, 32'(state), 32'(s));
    endtask

    // One instruction started from IDLE, returning to IDLE at writeback.
    task automatic run_one(input string name);
        run = 1'b1;
        step();
        run = 1'b0;
        wait_state(3'd0, 30, name);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [41:0] got;
        logic [41:0] exp;
        cyc++;
        if (state == 3'd1 && prev_state != 3'd1) fetch_start = cyc;
        prev_state = state;
        if (pc_enable === 1'b1) begin
            checks++;
            got = {regfile_we, pc_jump, instret, 8'(cyc - fetch_start + 1)};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected: got %h expected no pc_enable", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL retire{we,jump,instret,lat}: got %h expected %h", got, exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [2:0] nop_seq [12] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd5,
                                 3'd1, 3'd2, 3'd3, 3'd5};

    initial begin
        int n;
        reset = 1'b0;
        run = 1'b0;
        pc_in = 32'h0000_0100;
        is_mem = 1'b0; no_wb = 1'b0; illegal = 1'b0;
        is_branch = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
        mem_if.imem_valid = 1'b0;
        mem_if.imem_rdata = 32'd0;
        mem_if.dmem_done = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_state", 32'(state), 32'd0);
        check("rst_instr_out", instr_out, 32'h0000_0013);
        check("rst_instret", instret, 32'd0);
        check("rst_imem_req", 32'(mem_if.imem_req), 32'd0);
        check("rst_imem_addr", mem_if.imem_addr, 32'd0);
        check("rst_dmem_req", 32'(mem_if.dmem_req), 32'd0);
        check("rst_strobes", {29'd0, regfile_we, pc_enable, pc_jump}, 32'd0);
        check("rst_flags", {29'd0, instr_valid, halted, fault}, 32'd0);
        reset = 1'b1;
        step();
        check("idle_hold", 32'(state), 32'd0);

        // NOP stream, zero-wait fetch
        pc_in = 32'h0000_0080;
        mem_if.imem_valid = 1'b1;
        mem_if.imem_rdata = 32'h0000_0013;
        push_retire(1'b1, 1'b0, 32'd0, 8'd4);
        push_retire(1'b1, 1'b0, 32'd1, 8'd4);
        push_retire(1'b1, 1'b0, 32'd2, 8'd4);
        run = 1'b1;
        step();
        check("fetch_imem_req", 32'(mem_if.imem_req), 32'd1);
        check("fetch_imem_addr", mem_if.imem_addr, 32'h0000_0080);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("nop_state[%0d]", i), 32'(state), 32'(nop_seq[i]));
            check($sformatf("nop_pc_en[%0d]", i), 32'(pc_enable), 32'(nop_seq[i] == 3'd5));
            check($sformatf("nop_we[%0d]", i), 32'(regfile_we), 32'(nop_seq[i] == 3'd5));
            if (i == 8) run = 1'b0;
            step();
        end
        check("nop_instret_12", instret, 32'd3);
        check("nop_back_idle", 32'(state), 32'd0);

        // Branch taken / not taken
        is_branch = 1'b1; branch_taken = 1'b1; no_wb = 1'b1;
        mem_if.imem_rdata = 32'h0000_0463;
        push_retire(1'b0, 1'b1, 32'd3, 8'd4);
        run_one("br_taken_idle");
        check("br_instr_out", instr_out, 32'h0000_0463);
        branch_taken = 1'b0;
        push_retire(1'b0, 1'b0, 32'd4, 8'd4);
        run_one("br_not_taken_idle");

        // Load, dmem_done on third MEM cycle
        is_branch = 1'b0; no_wb = 1'b0; is_mem = 1'b1;
        mem_if.imem_rdata = 32'h0040_2083;
        push_retire(1'b1, 1'b0, 32'd5, 8'd7);
        run = 1'b1;
        step();
        run = 1'b0;
        wait_state(3'd4, 10, "ld_reach_mem");
        check("ld_instr_out", instr_out, 32'h0040_2083);
        check("ld_instr_valid", 32'(instr_valid), 32'd1);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            if (mem_if.dmem_req) n++;
            if (k == 2) mem_if.dmem_done = 1'b1;
            step();
        end
        mem_if.dmem_done = 1'b0;
        check("ld_dmem_req_cycles", 32'(n), 32'd3);
        check("ld_writeback", 32'(state), 32'd5);
        check("ld_dmem_req_off", 32'(mem_if.dmem_req), 32'd0);
        wait_state(3'd0, 10, "ld_back_idle");

        // Halt at instruction boundary
        is_mem = 1'b0;
        mem_if.imem_rdata = 32'h0000_0013;
        push_retire(1'b1, 1'b0, 32'd6, 8'd4);
        push_retire(1'b1, 1'b0, 32'd7, 8'd4);
        run = 1'b1;
        step();
        step();
        step();
        check("halt_in_execute", 32'(state), 32'd3);
        halt_req = 1'b1;
        step();
        step();
        check("halt_state", 32'(state), 32'd6);
        check("halt_halted", 32'(halted), 32'd1);
        step();
        check("halt_hold", 32'(state), 32'd6);
        halt_req = 1'b0;
        step();
        check("halt_release_fetch", 32'(state), 32'd1);
        check("halt_released", 32'(halted), 32'd0);
        run = 1'b0;
        wait_state(3'd0, 20, "halt_run_idle");
        check("halt_instret", instret, 32'd8);

        // Illegal instruction -> FAULT, no retirement
        illegal = 1'b1;
        run = 1'b1;
        step();
        run = 1'b0;
        step();
        step();
        illegal = 1'b0;
        check("ill_fault_state", 32'(state), 32'd7);
        check("ill_fault_flag", 32'(fault), 32'd1);
        for (int i = 0; i < 4; i++) begin
            run = (i % 2 == 0);
            step();
            check($sformatf("ill_sticky[%0d]", i), 32'(state), 32'd7);
        end
        check("ill_imem_req", 32'(mem_if.imem_req), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("ill_async_rst_state", 32'(state), 32'd0);
        check("ill_async_rst_fault", 32'(fault), 32'd0);
        check("ill_async_rst_instret", instret, 32'd0);
        run = 1'b0;
        step();
        reset = 1'b1;

        // Fetch timeout
        mem_if.imem_valid = 1'b0;
        run = 1'b1;
        step();
        n = 0;
        while (state == 3'd1 && n < 30) begin
            n++;
            step();
        end
        check("to_fetch_cycles", 32'(n), 32'(TO));
        check("to_fault_state", 32'(state), 32'd7);
        check("to_fault_flag", 32'(fault), 32'd1);
        check("to_imem_req", 32'(mem_if.imem_req), 32'd0);
        run = 1'b0;
        step();
        run = 1'b1;
        step();
        check("to_sticky", 32'(state), 32'd7);
        run = 1'b0;
        reset = 1'b0;
        step();
        check("to_rst_idle", 32'(state), 32'd0);
        check("to_rst_fault", 32'(fault), 32'd0);
        reset = 1'b1;
        mem_if.imem_valid = 1'b1;

        // Reset asserted mid-MEM
        is_mem = 1'b1;
        mem_if.imem_rdata = 32'h0040_2083;
        run = 1'b1;
        step();
        run = 1'b0;
        wait_state(3'd4, 10, "mrst_reach_mem");
        check("mrst_dmem_req_on", 32'(mem_if.dmem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mrst_dmem_req_off", 32'(mem_if.dmem_req), 32'd0);
        check("mrst_instret", instret, 32'd0);
        check("mrst_instr_out", instr_out, 32'h0000_0013);
        check("mrst_state", 32'(state), 32'd0);
        check("mrst_pc_enable", 32'(pc_enable), 32'd0);
        step();
        step();
        reset = 1'b1;
        is_mem = 1'b0;
        repeat (3) step();
        check("mrst_still_idle", 32'(state), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
